imem_loader: RTL and testbench

Instruction-memory loader for the 5-stage pipelined core. It writes a program image, one 32-bit word at a time, into the core's instruction memory through a valid/ready stream. It holds the pipeline in reset while loading and releases it once the image is complete and a settle interval has elapsed. It sits between the host/bench stimulus side and the processor, and is the writer for the pipeline's instruction-fetch read port.

---
 rtl/imem_loader.sv | 95 +++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams a program image into imem through a
// valid/ready port and holds the pipeline in reset until a settle interval has passed.
module imem_loader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              reload_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    // The entry edge counts as the first hold cycle, so the counter starts one short.
    localparam logic [7:0]        HOLD_INIT = 8'(HOLD_CYCLES - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [7:0]        hold_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            hold_cnt   <= '0;
            in_ready   <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= in_data;
                        if (word_count != MAX_COUNT)
                            word_count <= word_count + 1'b1;
                        // A full memory ends the load rather than wrapping onto address 0.
                        if (in_last || wr_ptr == LAST_ADDR) begin
                            state    <= HOLD;
                            in_ready <= 1'b0;
                            hold_cnt <= HOLD_INIT;
                            if (!in_last)
                                overflow <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state     <= RUN;
                        core_rst  <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                RUN: begin
                    if (reload_req) begin
                        state      <= LOAD;
                        in_ready   <= 1'b1;
                        core_rst   <= 1'b1;
                        load_done  <= 1'b0;
                        wr_ptr     <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (256-word and 8-word memories) checked every
// cycle against a transaction-level model, plus literal checks on the write log.
module tb_imem_loader;

    localparam int HOLD = 4;

    logic        CLK;
    logic        rst [2];
    logic        vld [2];
    logic        last[2];
    logic        rld [2];
    logic [31:0] din [2];

    logic        rdy_o [2];
    logic        we_o  [2];
    logic        crst_o[2];
    logic        ld_o  [2];
    logic        ovf_o [2];
    logic [31:0] wd_o  [2];
    logic [7:0]  addr0;
    logic [2:0]  addr1;
    logic [8:0]  cnt0;
    logic [3:0]  cnt1;

    imem_loader #(.ADDR_W(8), .DATA_W(32), .HOLD_CYCLES(HOLD)) dut0 (
        .CLK(CLK), .RST(rst[0]), .in_valid(vld[0]), .in_data(din[0]), .in_last(last[0]),
        .in_ready(rdy_o[0]), .reload_req(rld[0]), .mem_we(we_o[0]), .mem_addr(addr0),
        .mem_wdata(wd_o[0]), .core_rst(crst_o[0]), .load_done(ld_o[0]),
        .word_count(cnt0), .overflow(ovf_o[0]));

    imem_loader #(.ADDR_W(3), .DATA_W(32), .HOLD_CYCLES(HOLD)) dut1 (
        .CLK(CLK), .RST(rst[1]), .in_valid(vld[1]), .in_data(din[1]), .in_last(last[1]),
        .in_ready(rdy_o[1]), .reload_req(rld[1]), .mem_we(we_o[1]), .mem_addr(addr1),
        .mem_wdata(wd_o[1]), .core_rst(crst_o[1]), .load_done(ld_o[1]),
        .word_count(cnt1), .overflow(ovf_o[1]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: phase 0=loading, 1=settling, 2=running; tracks what each output must be.
    int          m_ph [2];
    int          m_ptr[2];
    int          m_cnt[2];
    int          m_hl [2];
    bit          m_ovf[2];
    bit          m_we [2];
    bit          m_rdy[2];
    bit          m_crst[2];
    bit          m_ld [2];
    logic [7:0]  m_addr[2];
    logic [31:0] m_wd [2];

    function automatic int depth(input int k);
        return (k == 0) ? 256 : 8;
    endfunction

    task automatic model_step(input int k);
        if (rst[k]) begin
            m_ph[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_hl[k] = 0; m_ovf[k] = 0;
            m_we[k] = 0; m_rdy[k] = 1; m_crst[k] = 1; m_ld[k] = 0;
            m_addr[k] = 0; m_wd[k] = 0;
        end else begin
            m_we[k] = 0;
            if (m_ph[k] == 0) begin
                if (vld[k]) begin
                    m_we[k] = 1;
                    m_addr[k] = 8'(m_ptr[k]);
                    m_wd[k] = din[k];
                    m_cnt[k]++;
                    if (last[k] || m_ptr[k] == depth(k) - 1) begin
                        if (!last[k]) m_ovf[k] = 1;
                        m_ph[k] = 1; m_hl[k] = HOLD; m_rdy[k] = 0;
                    end else begin
                        m_ptr[k]++;
                    end
                end
            end else if (m_ph[k] == 1) begin
                m_hl[k]--;
                if (m_hl[k] == 0) begin
                    m_ph[k] = 2; m_crst[k] = 0; m_ld[k] = 1;
                end
            end else if (rld[k]) begin
                m_ph[k] = 0; m_rdy[k] = 1; m_crst[k] = 1; m_ld[k] = 0;
                m_ptr[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            end
        end
    endtask

    logic [39:0] log0[$];
    logic [39:0] log1[$];

    function automatic logic [63:0] act_vec(input int k);
        logic [7:0] a;
        logic [8:0] c;
        a = (k == 0) ? addr0 : {5'b0, addr1};
        c = (k == 0) ? cnt0 : {5'b0, cnt1};
        return {10'b0, rdy_o[k], we_o[k], crst_o[k], ld_o[k], ovf_o[k], c, a, wd_o[k]};
    endfunction

    function automatic logic [63:0] exp_vec(input int k);
        return {10'b0, m_rdy[k], m_we[k], m_crst[k], m_ld[k], m_ovf[k], 9'(m_cnt[k]),
                m_addr[k], m_wd[k]};
    endfunction

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
            model_step(0);
            model_step(1);
            @(negedge CLK);
            chk("outputs_dut0", act_vec(0), exp_vec(0));
            chk("outputs_dut1", act_vec(1), exp_vec(1));
            if (we_o[0] === 1'b1) log0.push_back({addr0, wd_o[0]});
            if (we_o[1] === 1'b1) log1.push_back({5'b0, addr1, wd_o[1]});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_word(input int k, input logic [31:0] d, input bit l);
        vld[k] = 1'b1; din[k] = d; last[k] = l;
        tick();
        vld[k] = 1'b0; last[k] = 1'b0;
    endtask

    // Cycles from the current edge until core_rst drops, bounded.
    task automatic wait_run(input int k, output int n);
        n = 0;
        while (crst_o[k] !== 1'b0 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_reload(input int k);
        rld[k] = 1'b1;
        tick();
        rld[k] = 1'b0;
    endtask

    initial begin
        int n;
        int gaps[10];
        gaps = '{0, 2, 1, 0, 3, 0, 1, 2, 0, 0};
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; vld[k] = 1'b0; last[k] = 1'b0; rld[k] = 1'b0; din[k] = '0;
        end
        tick();
        chk("reset_core_rst", {63'b0, crst_o[0]}, 64'd1);
        chk("reset_in_ready", {63'b0, rdy_o[0]}, 64'd1);
        chk("reset_count", {55'b0, cnt0}, 64'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        idle(2);

        // Five back-to-back words, last on the fifth.
        log0.delete();
        for (int i = 0; i < 5; i++) send_word(0, 32'h13 + 32'(i), i == 4);
        wait_run(0, n);
        chk("t1_rst_release_cycles", 64'(n), 64'd4);
        idle(1);
        chk("t1_log_size", 64'(log0.size()), 64'd5);
        for (int i = 0; i < 5 && i < log0.size(); i++)
            chk("t1_write", {24'b0, log0[i]}, {24'b0, 8'(i), 32'h13 + 32'(i)});
        chk("t1_count", {55'b0, cnt0}, 64'd5);
        chk("t1_done_ovf", {62'b0, ld_o[0], ovf_o[0]}, 64'b10);

        // Reload from RUN, then a two-word image.
        pulse_reload(0);
        chk("reload_state", {61'b0, crst_o[0], rdy_o[0], ld_o[0]}, 64'b110);
        log0.delete();
        send_word(0, 32'hBEEF0000, 1'b0);
        send_word(0, 32'hBEEF0001, 1'b1);
        wait_run(0, n);
        idle(1);
        chk("reload_log_size", 64'(log0.size()), 64'd2);
        if (log0.size() == 2) begin
            chk("reload_addr0", {56'b0, log0[0][39:32]}, 64'd0);
            chk("reload_addr1", {56'b0, log0[1][39:32]}, 64'd1);
        end
        chk("reload_count", {55'b0, cnt0}, 64'd2);

        // Ten words with idle gaps between them.
        pulse_reload(0);
        log0.delete();
        for (int i = 0; i < 10; i++) begin
            send_word(0, 32'hA0 + 32'(i), i == 9);
            idle(gaps[i]);
        end
        wait_run(0, n);
        idle(1);
        chk("gaps_log_size", 64'(log0.size()), 64'd10);
        for (int i = 0; i < 10 && i < log0.size(); i++)
            chk("gaps_write", {24'b0, log0[i]}, {24'b0, 8'(i), 32'hA0 + 32'(i)});

        // Small memory fills without in_last.
        log1.delete();
        for (int i = 0; i < 8; i++) send_word(1, 32'h100 + 32'(i), 1'b0);
        chk("ovf_flag", {63'b0, ovf_o[1]}, 64'd1);
        chk("ovf_count", {60'b0, cnt1}, 64'd8);
        chk("ovf_ready", {63'b0, rdy_o[1]}, 64'd0);
        vld[1] = 1'b1; din[1] = 32'hDEAD; idle(3); vld[1] = 1'b0;
        chk("ovf_log_size", 64'(log1.size()), 64'd8);
        if (log1.size() == 8) chk("ovf_last_addr", {56'b0, log1[7][39:32]}, 64'd7);
        wait_run(1, n);
        pulse_reload(1);
        send_word(1, 32'h55, 1'b0);
        send_word(1, 32'h56, 1'b1);
        idle(1);
        chk("ovf_cleared", {63'b0, ovf_o[1]}, 64'd0);
        chk("ovf_reload_count", {60'b0, cnt1}, 64'd2);
        wait_run(1, n);

        // RST after three of six words.
        pulse_reload(0);
        for (int i = 0; i < 3; i++) send_word(0, 32'hC0 + 32'(i), 1'b0);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        chk("midrst_outputs", {55'b0, cnt0}, 64'd0);
        chk("midrst_flags", {60'b0, crst_o[0], rdy_o[0], we_o[0], ld_o[0]}, 64'b1100);
        chk("midrst_addr", {56'b0, addr0}, 64'd0);
        log0.delete();
        send_word(0, 32'hD0, 1'b0);
        send_word(0, 32'hD1, 1'b1);
        idle(1);
        if (log0.size() > 0) chk("midrst_restart_addr", {56'b0, log0[0][39:32]}, 64'd0);
        else chk("midrst_restart_log", 64'd0, 64'd1);
        wait_run(0, n);

        // reload_req in LOAD and HOLD is ignored; HOLD length unchanged.
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        rld[0] = 1'b1;
        send_word(0, 32'hE0, 1'b0);
        send_word(0, 32'hE1, 1'b1);
        chk("rld_hold_ready", {63'b0, rdy_o[0]}, 64'd0);
        tick();
        rld[0] = 1'b0;
        wait_run(0, n);
        chk("rld_hold_cycles", 64'(n + 1), 64'd4);
        chk("rld_count", {55'b0, cnt0}, 64'd2);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
